// File: rtl/de_multiplexer_if.sv
// Bus bundle for the registered 1-to-2 demultiplexer.
// The producer/bench side uses "master"; the demultiplexer uses "slave".
interface de_multiplexer_if #(
  parameter int WIDTH = 2
) ();
  logic [WIDTH-1:0] A;
  logic [1:0]       S;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic             B_vld;
  logic             C_vld;
  logic             err;

  modport master (output A, output S, input B, input C, input B_vld, input C_vld, input err);
  modport slave  (input A, input S, output B, output C, output B_vld, output C_vld, output err);
endinterface

// File: rtl/de_multiplexer.sv
// Registered 1-to-2 demultiplexer: steers word A to B, C, both or neither
// according to S, with per-output valid strobes and a reserved-code error flag.
// Every output is registered, giving a fixed one-cycle latency.
module de_multiplexer #(
  parameter int WIDTH     = 2,
  parameter bit IDLE_ZERO = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  de_multiplexer_if.slave bus
);

  localparam logic [1:0] SEL_B     = 2'b00;
  localparam logic [1:0] SEL_C     = 2'b01;
  localparam logic [1:0] SEL_BOTH  = 2'b10;

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             b_vld_q, b_vld_d;
  logic             c_vld_q, c_vld_d;
  logic             err_q, err_d;

  // Decode the routing code; unselected outputs either clear or hold.
  always_comb begin
    b_d     = IDLE_ZERO ? '0 : b_q;
    c_d     = IDLE_ZERO ? '0 : c_q;
    b_vld_d = 1'b0;
    c_vld_d = 1'b0;
    err_d   = 1'b0;
    case (bus.S)
      SEL_B: begin
        b_d     = bus.A;
        b_vld_d = 1'b1;
      end
      SEL_C: begin
        c_d     = bus.A;
        c_vld_d = 1'b1;
      end
      SEL_BOTH: begin
        b_d     = bus.A;
        c_d     = bus.A;
        b_vld_d = 1'b1;
        c_vld_d = 1'b1;
      end
      default: begin
        // Reserved code: nothing is delivered, only the error strobe fires.
        err_d = 1'b1;
      end
    endcase
  end

  // Output registers; the active-low reset discards any in-flight word at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_q     <= '0;
      c_q     <= '0;
      b_vld_q <= 1'b0;
      c_vld_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      b_q     <= b_d;
      c_q     <= c_d;
      b_vld_q <= b_vld_d;
      c_vld_q <= c_vld_d;
      err_q   <= err_d;
    end
  end

  assign bus.B     = b_q;
  assign bus.C     = c_q;
  assign bus.B_vld = b_vld_q;
  assign bus.C_vld = c_vld_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_de_multiplexer.sv
// Bench for de_multiplexer: one instance per idle policy, both fed the same
// stimulus and compared against a routing model kept here.
module tb_de_multiplexer;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  de_multiplexer_if #(.WIDTH(2)) if1 ();  // IDLE_ZERO = 1
  de_multiplexer_if #(.WIDTH(2)) if0 ();  // IDLE_ZERO = 0

  de_multiplexer #(.WIDTH(2), .IDLE_ZERO(1'b1)) dut_zero (.clk(clk), .rst(rst), .bus(if1));
  de_multiplexer #(.WIDTH(2), .IDLE_ZERO(1'b0)) dut_hold (.clk(clk), .rst(rst), .bus(if0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: index 1 = clear-when-idle instance, index 0 = hold instance.
  logic [1:0] mb [2];
  logic [1:0] mc [2];
  logic       mbv, mcv, merr;

  wire [6:0] obs1 = {if1.B, if1.C, if1.B_vld, if1.C_vld, if1.err};
  wire [6:0] obs0 = {if0.B, if0.C, if0.B_vld, if0.C_vld, if0.err};

  function automatic logic [6:0] exp_vec(input int z);
    return {mb[z], mc[z], mbv, mcv, merr};
  endfunction

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      mb[z] = 2'b00;
      mc[z] = 2'b00;
    end
    mbv  = 1'b0;
    mcv  = 1'b0;
    merr = 1'b0;
  endtask

  // What one clock edge does: which outputs receive A, and what idle outputs do.
  task automatic model_edge(input logic [1:0] a, input logic [1:0] s);
    bit to_b, to_c;
    to_b = (s == 2'd0) || (s == 2'd2);
    to_c = (s == 2'd1) || (s == 2'd2);
    for (int z = 0; z < 2; z++) begin
      mb[z] = to_b ? a : ((z == 1) ? 2'b00 : mb[z]);
      mc[z] = to_c ? a : ((z == 1) ? 2'b00 : mc[z]);
    end
    mbv  = to_b;
    mcv  = to_c;
    merr = (s == 2'd3);
  endtask

  task automatic drive(input logic [1:0] a, input logic [1:0] s);
    if1.A = a; if0.A = a;
    if1.S = s; if0.S = s;
  endtask

  // Drive A/S, let one edge pass, then advance the model.
  task automatic step(input logic [1:0] a, input logic [1:0] s);
    drive(a, s);
    @(posedge clk);
    #1;
    model_edge(a, s);
  endtask

  task automatic test_reset();
    model_reset();
    checks++;
    if ({obs1, obs0} !== {exp_vec(1), exp_vec(0)})
      $display("FAIL reset_state: got %b/%b want %b/%b", obs1, obs0, exp_vec(1), exp_vec(0));
    else passed++;
    rst = 1'b1;
    step(2'b10, 2'b10);
    checks++;
    if ({obs1, obs0} !== {exp_vec(1), exp_vec(0)})
      $display("FAIL reset_preload: got %b/%b want %b/%b", obs1, obs0, exp_vec(1), exp_vec(0));
    else passed++;
    #3;
    drive(2'b11, 2'b00);
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({obs1, obs0} !== 14'b0)
      $display("FAIL reset_async: got %b/%b want all zero", obs1, obs0);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if ({obs1, obs0} !== 14'b0)
      $display("FAIL reset_held: got %b/%b want all zero", obs1, obs0);
    else passed++;
    #2;
    rst = 1'b1;
    step(2'b11, 2'b00);
    checks++;
    if (if1.B !== 2'b11 || if1.B_vld !== 1'b1 || obs1 !== exp_vec(1) || obs0 !== exp_vec(0))
      $display("FAIL reset_release: got %b/%b want %b/%b", obs1, obs0, exp_vec(1), exp_vec(0));
    else passed++;
    $display("test_reset done");
  endtask

  task automatic test_routing();
    step(2'b01, 2'b00);
    checks++;
    if (obs1 !== 7'b01_00_100 || obs0 !== exp_vec(0))
      $display("FAIL route_b: got %b/%b want 0100100/%b", obs1, obs0, exp_vec(0));
    else passed++;
    step(2'b10, 2'b01);
    checks++;
    if (obs1 !== 7'b00_10_010 || obs0 !== exp_vec(0))
      $display("FAIL route_c: got %b/%b want 0010010/%b", obs1, obs0, exp_vec(0));
    else passed++;
    $display("test_routing done");
  endtask

  task automatic test_broadcast();
    step(2'b11, 2'b10);
    checks++;
    if (obs1 !== 7'b11_11_110 || obs0 !== 7'b11_11_110)
      $display("FAIL broadcast: got %b/%b want 1111110", obs1, obs0);
    else passed++;
    $display("test_broadcast done");
  endtask

  task automatic test_reserved();
    step(2'b01, 2'b00);
    step(2'b10, 2'b11);
    checks++;
    if (obs1 !== 7'b00_00_001 || obs0 !== exp_vec(0) || if0.B !== 2'b01 || if0.err !== 1'b1)
      $display("FAIL reserved: got %b/%b want 0000001/%b", obs1, obs0, exp_vec(0));
    else passed++;
    $display("test_reserved done");
  endtask

  task automatic test_hold();
    step(2'b10, 2'b00);
    checks++;
    if (obs0 !== exp_vec(0) || obs1 !== exp_vec(1))
      $display("FAIL hold_load: got %b/%b want %b/%b", obs0, obs1, exp_vec(0), exp_vec(1));
    else passed++;
    step(2'b01, 2'b01);
    checks++;
    if (if0.B !== 2'b10 || if0.C !== 2'b01 || if0.err !== 1'b0 || obs0 !== exp_vec(0))
      $display("FAIL hold_keep: got %b want %b", obs0, exp_vec(0));
    else passed++;
    $display("test_hold done");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      step(2'($urandom), 2'(i % 2));
      checks++;
      if (obs1 !== exp_vec(1) || obs0 !== exp_vec(0))
        $display("FAIL mid_traffic_%0d: got %b/%b want %b/%b", i, obs1, obs0, exp_vec(1), exp_vec(0));
      else passed++;
      if (i == 3) begin
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({obs1, obs0} !== {exp_vec(1), exp_vec(0)})
          $display("FAIL mid_reset: got %b/%b want all zero", obs1, obs0);
        else passed++;
        #2;
        rst = 1'b1;
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom), 2'($urandom_range(0, 3)));
      checks++;
      if (obs1 !== exp_vec(1) || obs0 !== exp_vec(0))
        $display("FAIL random_%0d: got %b/%b want %b/%b", i, obs1, obs0, exp_vec(1), exp_vec(0));
      else passed++;
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b0;
    drive(2'b00, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_routing();
    test_broadcast();
    test_reserved();
    test_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/de_multiplexer.md
# de_multiplexer

Registered 1-to-2 demultiplexer: routes a WIDTH-bit input word A to output B, output C, both, or neither, according to a 2-bit select S. It sits between a single producer and two consumers as a synchronous steering stage. Outputs are registered, so each routing decision takes one clock. Per-output valid strobes and an error strobe let downstream logic know when data was delivered.

## Interface
- WIDTH, default 2: data width of A, B and C.
- IDLE_ZERO, default 1: 1 = an unselected output is driven to 0; 0 = an unselected output holds its last value.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- A  in  WIDTH  input data word.
- S  in  2  select / routing code.
- B  out  WIDTH  output line 0, registered.
- C  out  WIDTH  output line 1, registered.
- B_vld  out  1  B was loaded from A on the last clock edge.
- C_vld  out  1  C was loaded from A on the last clock edge.
- err  out  1  the last sampled S was the reserved code.

## Operation
- S is decoded on every rising clk edge:
  - S=2'b00: B <= A; B_vld <= 1; C_vld <= 0.
  - S=2'b01: C <= A; C_vld <= 1; B_vld <= 0.
  - S=2'b10 (broadcast): B <= A and C <= A; B_vld <= 1 and C_vld <= 1.
  - S=2'b11 (reserved): no output is loaded; B_vld <= 0, C_vld <= 0, err <= 1.
- err <= 0 for every S other than 2'b11.
- Unselected outputs, including both outputs for S=2'b11:
  - IDLE_ZERO=1: the output is cleared to 0.
  - IDLE_ZERO=0: the output holds its value.
- The data path performs no arithmetic. A is copied bit-exact; there is no width conversion.
- No handshake: the downstream side must accept data on the cycle its vld flag is high.
- A and S are sampled together. A new routing code takes effect on the next edge, with no inter-cycle dependence other than hold mode.

## Timing
- Latency: exactly 1 clk cycle from A/S sampled to B/C/vld/err valid.
- Throughput: one word per clock; back-to-back select changes are honoured every cycle.
- Reset (rst=0): asynchronously forces B=0, C=0, B_vld=0, C_vld=0, err=0, independent of clk.
  - The outputs stay at these values while rst=0.
  - Reset asserted mid-stream discards any in-flight word.
- Reset release: the first rising edge with rst=1 samples A/S normally. There is no extra flush cycle.
- S changing between edges has no effect until the next edge. Glitches on S/A between edges are ignored.
- Hold mode (IDLE_ZERO=0) after reset: an unselected output holds 0 until it is first loaded.

## Test plan
- Reset, WIDTH=2: assert rst=0 asynchronously with A=2'b11, S=2'b00 -> B=0, C=0, all strobes 0 immediately; release -> next edge B=2'b11, B_vld=1.
- Routing, IDLE_ZERO=1: the following sequence on consecutive edges
  - A=2'b01, S=00 -> B=01, C=00, B_vld=1, C_vld=0.
  - A=2'b10, S=01 -> B=00, C=10, B_vld=0, C_vld=1.
- Broadcast: A=2'b11, S=10 -> B=11, C=11, both vld=1, err=0.
- Reserved code:
  - IDLE_ZERO=1, S=11 after B=01 -> B=00, C=00, vlds 0, err=1.
  - IDLE_ZERO=0, same stimulus -> B stays 01, C unchanged, err=1.
- Hold mode, IDLE_ZERO=0: load B=10 (S=00), then S=01 with A=01 -> B stays 10, C=01; err=0 throughout.
- Reset mid-operation: during alternating S=00/01 traffic, pulse rst low between edges -> all outputs 0 within the pulse; traffic resumes correctly on the first edge after release.
